// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//    Sole master of a 256x32 single-port RAM. Accepts one read/write request
//    at a time over a valid/ready handshake. It returns exactly one response
//    per request. The RAM has no byte lanes, so a partial-word write (byte
//    enables not all set) is done as read-modify-write.
//
// Ports
//    CLK, RST                     clock (rising edge), synchronous active-high reset
//    req_valid/req_ready          request handshake
//    req_we, req_addr,
//    req_wdata, req_be            request payload (be[i] covers bits [8i+7:8i])
//    rsp_valid/rsp_ready          response handshake
//    rsp_rdata                    read word, or final word written
//    ram_addr, ram_din, ram_rw    RAM pins (ram_rw=1 commits ram_din at the edge)
//    ram_dout                     RAM read data, valid the cycle after the address
//    busy                         controller not idle

module ram_access_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_rw,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   localparam int NBYTES = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_RD_CAP = 3'd2,
      S_WR     = 3'd3,
      S_RSP    = 3'd4
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr_q;
   logic [DATA_W-1:0]   r_wdata_q;
   logic [NBYTES-1:0]   r_be_q;
   logic                r_we_q;
   logic [DATA_W-1:0]   r_rdata_q;
   logic                r_rsp_valid;
   logic                r_busy;

   logic [DATA_W-1:0]   w_merge;
   logic                w_accept;

   // Byte merge for read-modify-write: enabled bytes come from the request,
   // the rest from the word just read.
   always_comb begin
      w_merge = ram_dout;
      for (int i = 0; i < NBYTES; i++) begin
         if (r_be_q[i]) w_merge[8*i +: 8] = r_wdata_q[8*i +: 8];
      end
   end

   assign req_ready = (r_state == S_IDLE) & ~RST;
   assign w_accept  = req_valid & req_ready;

   // The address is always driven from addr_q. Outside WR it is only a
   // harmless read. The write strobe is gated by RST so that an abort never
   // commits a word.
   assign ram_addr  = r_addr_q;
   assign ram_din   = r_wdata_q;
   assign ram_rw    = (r_state == S_WR) & ~RST;

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata_q;
   assign busy      = r_busy;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_addr_q    <= '0;
         r_wdata_q   <= '0;
         r_be_q      <= '0;
         r_we_q      <= 1'b0;
         r_rdata_q   <= '0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr_q  <= req_addr;
                  r_we_q    <= req_we;
                  r_wdata_q <= req_wdata;
                  r_be_q    <= req_be;
                  r_busy    <= 1'b1;
                  // Only a full-word write can skip the read.
                  if (req_we && (req_be == 4'hF)) r_state <= S_WR;
                  else                            r_state <= S_RD;
               end
            end
            S_RD: begin
               r_state <= S_RD_CAP;
            end
            S_RD_CAP: begin
               r_rdata_q <= ram_dout;
               if (r_we_q && (r_be_q != '0)) begin
                  r_wdata_q <= w_merge;
                  r_state   <= S_WR;
               end else begin
                  // Read, or a be=0 write that leaves the RAM untouched.
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RSP;
               end
            end
            S_WR: begin
               r_rdata_q   <= r_wdata_q;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RSP;
            end
            S_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [7:0]  ram_addr;
   logic [31:0] ram_din;
   logic        ram_rw;
   logic [31:0] ram_dout;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   // RAM model: synchronous write, registered read.
   logic [31:0] mem [256];
   int          wr_cnt = 0;
   logic [7:0]  last_waddr = '0;
   logic [31:0] last_wdata = '0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      ram_dout = 32'h0;
   end

   always @(posedge CLK) begin
      if (ram_rw) begin
         mem[ram_addr] <= ram_din;
         wr_cnt        <= wr_cnt + 1;
         last_waddr    <= ram_addr;
         last_wdata    <= ram_din;
      end
      ram_dout <= mem[ram_addr];
   end

   always #5 CLK = ~CLK;

   ram_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_rw    (ram_rw),
      .ram_dout  (ram_dout),
      .busy      (busy)
   );

   // Stimulus: present one request and return the latency in edges, counting
   // the accept edge as the first. A value of -1 means no response came.
   task automatic issue(input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int lat);
      int guard;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge CLK); #1;
         guard++;
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge CLK); #1;
         lat++;
      end
      if (!rsp_valid) lat = -1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      n_vec++;
      if ({rsp_valid, ram_rw, busy, req_ready} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctrl: got v/rw/busy/rdy=%b expected 0000",
                  {rsp_valid, ram_rw, busy, req_ready});
      end
      n_vec++;
      if (rsp_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
      end
      RST = 1'b0;
      #1;
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b expected 1", req_ready);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_full_write();
      int lat, base;
      base = wr_cnt;
      issue(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, lat);
      n_vec++;
      if (lat !== 2) begin
         n_err++; $display("FAIL fw_latency: got %0d expected 2", lat);
      end
      n_vec++;
      if (rsp_rdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL fw_rdata: got %h expected DEADBEEF", rsp_rdata);
      end
      n_vec++;
      if (wr_cnt - base !== 1 || last_waddr !== 8'h05 || last_wdata !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL fw_ram_write: got count=%0d addr=%h data=%h expected 1/05/DEADBEEF",
                  wr_cnt - base, last_waddr, last_wdata);
      end
      @(posedge CLK); #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL fw_complete: got v=%b busy=%b expected 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
      int lat, base;
      base = wr_cnt;
      issue(1'b0, addr, 32'hFFFFFFFF, 4'hF, lat);
      n_vec++;
      if (lat !== 3) begin
         n_err++; $display("FAIL %s_latency: got %0d expected 3", tag, lat);
      end
      n_vec++;
      if (rsp_rdata !== exp) begin
         n_err++; $display("FAIL %s_rdata: got %h expected %h", tag, rsp_rdata, exp);
      end
      n_vec++;
      if (wr_cnt != base) begin
         n_err++; $display("FAIL %s_no_write: got %0d writes expected 0", tag, wr_cnt - base);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_partial_write();
      int lat, base;
      base = wr_cnt;
      issue(1'b1, 8'h05, 32'h11223344, 4'b0101, lat);
      n_vec++;
      if (lat !== 4) begin
         n_err++; $display("FAIL pw_latency: got %0d expected 4", lat);
      end
      n_vec++;
      if (rsp_rdata !== 32'hDE22BE44) begin
         n_err++; $display("FAIL pw_rdata: got %h expected DE22BE44", rsp_rdata);
      end
      n_vec++;
      if (wr_cnt - base !== 1 || mem[8'h05] !== 32'hDE22BE44) begin
         n_err++;
         $display("FAIL pw_ram: got count=%0d mem=%h expected 1/DE22BE44",
                  wr_cnt - base, mem[8'h05]);
      end
      @(posedge CLK); #1;
      test_read(8'h05, 32'hDE22BE44, "pw_readback");
   endtask

   task automatic test_be0_write();
      int lat, base;
      base = wr_cnt;
      issue(1'b1, 8'h05, 32'h55555555, 4'b0000, lat);
      n_vec++;
      if (lat !== 3) begin
         n_err++; $display("FAIL be0_latency: got %0d expected 3", lat);
      end
      n_vec++;
      if (rsp_rdata !== 32'hDE22BE44) begin
         n_err++; $display("FAIL be0_rdata: got %h expected DE22BE44", rsp_rdata);
      end
      n_vec++;
      if (wr_cnt != base || mem[8'h05] !== 32'hDE22BE44) begin
         n_err++;
         $display("FAIL be0_untouched: got count=%0d mem=%h expected 0/DE22BE44",
                  wr_cnt - base, mem[8'h05]);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      int guard;
      issue(1'b1, 8'hFF, 32'hCAFEF00D, 4'hF, lat);
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      issue(1'b0, 8'hFF, 32'h0, 4'h0, lat);
      n_vec++;
      if (lat !== 3 || rsp_rdata !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL bp_read: got lat=%0d data=%h expected 3/CAFEF00D", lat, rsp_rdata);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || req_ready !== 1'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_err++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
      end
      // Request presented in the completing cycle must wait one cycle.
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h05;
      @(posedge CLK); #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: got v=%b busy=%b rdy=%b expected 0/0/1",
                  rsp_valid, busy, req_ready);
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL bp_next_accept: got busy=%b expected 1", busy);
      end
      guard = 0;
      while (!rsp_valid && guard < 20) begin
         @(posedge CLK); #1;
         guard++;
      end
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) begin
         n_err++;
         $display("FAIL bp_next_rsp: got v=%b data=%h expected 1/DE22BE44", rsp_valid, rsp_rdata);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_mid_write();
      int base;
      base = wr_cnt;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'h40;
      req_wdata = 32'hAAAAAAAA;
      req_be    = 4'hF;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      // Now in WR: abort with reset before the edge that would commit.
      RST = 1'b1;
      #1;
      n_vec++;
      if (ram_rw !== 1'b0 || req_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_wr_gate: got rw=%b rdy=%b expected 0/0", ram_rw, req_ready);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rst_abort_state: got busy=%b v=%b data=%h expected 0/0/00000000",
                  busy, rsp_valid, rsp_rdata);
      end
      n_vec++;
      if (wr_cnt != base || mem[8'h40] !== 32'h0) begin
         n_err++;
         $display("FAIL rst_no_commit: got count=%0d mem=%h expected 0/00000000",
                  wr_cnt - base, mem[8'h40]);
      end
      @(posedge CLK); #1;
      test_read(8'h40, 32'h00000000, "rst_readback");
   endtask

   initial begin
      RST       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'h0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b1;
      #1;
      test_reset();
      test_full_write();
      test_read(8'h05, 32'hDEADBEEF, "rd");
      test_partial_write();
      test_be0_write();
      test_backpressure();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Request sequencer that sits directly upstream of the 256x32 RAM and is its only master.
- Accepts single-word read/write requests over a valid/ready handshake and drives the RAM's Addr/DataIn/RW pins.
- Captures the RAM's registered read data and returns exactly one response per request.
- Partial-word writes with byte enables are done as read-modify-write, because the RAM has no byte lanes.

Parameters:
- ADDR_W, 8, word-address width; matches RAM depth of 256.
- DATA_W, 32, data width; must be 32, the byte-enable width DATA_W/8 is fixed at 4.

Ports:
- CLK  in  1  single clock, rising edge; same clock as the RAM.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  4  byte enables; be[3] maps to bits [31:24], be[0] maps to bits [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read: word read; write: final word written; be=0 write: current word.
- ram_addr  out  ADDR_W  drives RAM Addr.
- ram_din  out  DATA_W  drives RAM DataIn.
- ram_rw  out  1  drives RAM RW; 1 = write.
- ram_dout  in  DATA_W  RAM DataOut; registered inside the RAM.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- RAM timing contract:
  - Write: the RAM commits ram_din at the edge ending any cycle with ram_rw=1.
  - Read: ram_addr is presented with ram_rw=0 in cycle N; ram_dout is valid during cycle N+1.
- Reset (RST high at an edge):
  - state is IDLE; addr_q, wdata_q, be_q, we_q and rdata_q are 0.
  - rsp_valid=0, rsp_rdata=0, ram_rw=0, busy=0.
  - req_ready=0 while RST is high.
- Mid-operation reset: the transaction is aborted with no response.
  - ram_rw = (state==WR) & ~RST, so no write is committed in a cycle where RST is high.
- State IDLE:
  - req_ready=1.
  - On an edge with req_valid&req_ready: latch addr/we/wdata/be into the _q registers.
  - Next state is WR if we=1 and be=4'hF; otherwise RD.
- State RD: ram_addr=addr_q, ram_rw=0. Next state is RD_CAP.
- State RD_CAP: capture ram_dout into rdata_q at the edge.
  - If we_q=1 and be_q!=0: wdata_q becomes the merge of ram_dout, taking each byte i from wdata_q where be_q[i]=1. Next state is WR.
  - Otherwise the next state is RSP and rsp_rdata = captured word.
- State WR: ram_addr=addr_q, ram_din=wdata_q, ram_rw=1.
  - Next state is RSP; rsp_rdata = wdata_q (the word written).
- State RSP: rsp_valid=1, rsp_rdata held stable.
  - On an edge with rsp_ready=1: next state IDLE, rsp_valid drops.
  - rsp_ready low holds RSP indefinitely; no new request is accepted.
- Outside RD/RD_CAP/WR: ram_rw=0 and ram_addr=addr_q (a harmless read).
- Latency, counted as edges from the accept edge to the first cycle with rsp_valid=1:
  - full write: 2
  - read: 3
  - be=0 write: 3 (read-only, RAM untouched)
  - partial write: 4
- Throughput: one outstanding request. req_ready is 0 from the accept edge until the state returns to IDLE.
  - A request presented in the same cycle a response completes is accepted on the following cycle, not that cycle.
- Address wrap: none; an 8-bit address covers the whole RAM. ADDR 8'hFF is legal.
- Ignored inputs:
  - req_wdata and req_be are ignored for reads.
  - Inputs are not sampled outside the IDLE accept cycle.

Test Plan:
- Reset, then full write: addr 8'h05, wdata 32'hDEADBEEF, be 4'hF.
  - ram_rw=1 for exactly one cycle, with ram_addr=05.
  - rsp_valid at accept+2 with rsp_rdata=DEADBEEF.
- Read addr 8'h05 after the write above: rsp_valid at accept+3, rsp_rdata=32'hDEADBEEF, ram_rw stays 0.
- Partial write to addr 05: wdata 32'h11223344, be 4'b0101.
  - RD, RD_CAP, WR sequence; RAM written with 32'hDE22BE44.
  - rsp at accept+4 with rsp_rdata=DE22BE44; a read-back returns DE22BE44.
- be=0 write to addr 05: no ram_rw pulse; rsp_rdata=DE22BE44 at accept+3.
- Backpressure, then reset:
  - Read addr 8'hFF with rsp_ready held 0 for 5 cycles: rsp_valid and rsp_rdata stay stable, req_ready stays 0; completes when rsp_ready=1.
  - Assert RST during WR of a write to addr 8'h40 (wdata 32'hAAAAAAAA, prior value 32'h0): no RAM write occurs, state is IDLE, rsp_valid=0.
  - A subsequent read of addr 8'h40 returns the prior value 32'h00000000.
